// File: rtl/channel_dispatcher_pkg.sv
// Width helpers shared by the channel dispatcher, its interface and its round-robin picker.
// Optional feature macro: CHANNEL_DISPATCHER_STALL_CNT_EN (stall counter output).
package channel_dispatch_pkg;

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int crd_w(input int m);
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/channel_dispatcher_if.sv
// Upstream payload, downstream demux beat and status signals of the channel dispatcher.
// Optional feature macro: CHANNEL_DISPATCHER_STALL_CNT_EN adds o_stall_cnt.
interface channel_dispatcher_if
   import channel_dispatch_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_OUTPUT = 8
);
   localparam int SEL_W = sel_w(NUM_OUTPUT);

   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_valid;
   logic                  o_ready;
   logic                  i_credit_return [NUM_OUTPUT];
   logic [DATA_WIDTH-1:0] o_data;
   logic [SEL_W-1:0]      o_sel;
   logic                  o_valid;
   logic                  o_credit_err;
`ifdef CHANNEL_DISPATCHER_STALL_CNT_EN
   logic [31:0]           o_stall_cnt;

   modport master (
      output i_data, i_valid, i_credit_return,
      input  o_ready, o_data, o_sel, o_valid, o_credit_err, o_stall_cnt
   );

   modport slave (
      input  i_data, i_valid, i_credit_return,
      output o_ready, o_data, o_sel, o_valid, o_credit_err, o_stall_cnt
   );
`else
   modport master (
      output i_data, i_valid, i_credit_return,
      input  o_ready, o_data, o_sel, o_valid, o_credit_err
   );

   modport slave (
      input  i_data, i_valid, i_credit_return,
      output o_ready, o_data, o_sel, o_valid, o_credit_err
   );
`endif

endinterface

// File: rtl/channel_dispatcher_rr_picker.sv
// Purely combinational round-robin search: first eligible index at or above ptr, wrapping at N-1.
module rr_picker #(
   parameter int N     = 8,
   parameter int SEL_W = 3
) (
   input  logic             eligible [N],
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N) s = s - N;
      return SEL_W'(s);
   endfunction

   // Scan from the farthest offset down so the nearest eligible channel wins last.
   always_comb begin
      // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
      any = 1'b0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (eligible[wrap_add(ptr, k)]) begin
            any = 1'b1;
            idx = wrap_add(ptr, k);
         end
      end
   end

endmodule

// File: rtl/channel_dispatcher.sv
// Credit-based round-robin dispatcher feeding a registered beat to a 1-to-N demux.
// Optional feature macro: CHANNEL_DISPATCHER_STALL_CNT_EN adds a saturating 32-bit stall counter.
module channel_dispatcher
   import channel_dispatch_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_OUTPUT = 8,
   parameter int CREDIT_MAX = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   channel_dispatcher_if.slave bus
);

   localparam int SEL_W = sel_w(NUM_OUTPUT);
   localparam int CRD_W = crd_w(CREDIT_MAX);
   localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CREDIT_MAX);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUTPUT - 1);

   logic [CRD_W-1:0]      credit_q [NUM_OUTPUT];
   logic [CRD_W-1:0]      credit_d [NUM_OUTPUT];
   logic                  eligible [NUM_OUTPUT];
   logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic                  pick_any;
   logic [SEL_W-1:0]      pick_idx;
   logic                  accept;

   // Eligibility comes only from registered credits; returns are never forwarded.
   always_comb begin
      for (int i = 0; i < NUM_OUTPUT; i++) begin
         eligible[i] = (credit_q[i] != '0);
      end
   end

   rr_picker #(
      .N     (NUM_OUTPUT),
      .SEL_W (SEL_W)
   ) u_rr_picker (
      .eligible (eligible),
      .ptr      (rr_ptr_q),
      .any      (pick_any),
      .idx      (pick_idx)
   );

   assign accept = bus.i_valid && pick_any;

   always_comb begin
      data_d   = data_q;
      sel_d    = sel_q;
      valid_d  = accept;
      rr_ptr_d = rr_ptr_q;
      err_d    = err_q;
      if (accept) begin
         data_d   = bus.i_data;
         sel_d    = pick_idx;
         rr_ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
      end
      for (int i = 0; i < NUM_OUTPUT; i++) begin
         credit_d[i] = credit_q[i];
         if (accept && (pick_idx == SEL_W'(i)) && !bus.i_credit_return[i]) begin
            credit_d[i] = credit_q[i] - 1'b1;
         end else if (bus.i_credit_return[i] && !(accept && (pick_idx == SEL_W'(i)))) begin
            if (credit_q[i] == CRD_FULL) begin
               err_d = 1'b1;
            end else begin
               credit_d[i] = credit_q[i] + 1'b1;
            end
         end
      end
   end

   // NOTE: the credit array is a bank of flops, not a RAM, so it is reset to full like any other state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         data_q   <= '0;
         sel_q    <= '0;
         valid_q  <= 1'b0;
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < NUM_OUTPUT; i++) begin
            credit_q[i] <= CRD_FULL;
         end
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge state.
         data_q   <= data_d;
         sel_q    <= sel_d;
         valid_q  <= valid_d;
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
         for (int i = 0; i < NUM_OUTPUT; i++) begin
            credit_q[i] <= credit_d[i];
         end
      end
   end

   assign bus.o_ready      = pick_any;
   assign bus.o_data       = data_q;
   assign bus.o_sel        = sel_q;
   assign bus.o_valid      = valid_q;
   assign bus.o_credit_err = err_q;

`ifdef CHANNEL_DISPATCHER_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (bus.i_valid && !pick_any && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign bus.o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_channel_dispatcher.sv
// Directed bench for channel_dispatcher with NUM_OUTPUT=4, CREDIT_MAX=2, DATA_WIDTH=16.
module tb_channel_dispatcher;

   localparam int DW = 16;
   localparam int NO = 4;
   localparam int CM = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   channel_dispatcher_if #(.DATA_WIDTH(DW), .NUM_OUTPUT(NO)) bus ();

   channel_dispatcher #(
      .DATA_WIDTH (DW),
      .NUM_OUTPUT (NO),
      .CREDIT_MAX (CM)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ret(input logic [NO-1:0] r);
      for (int i = 0; i < NO; i++) bus.i_credit_return[i] = r[i];
   endtask

   initial begin
      bus.i_data  = '0;
      bus.i_valid = 1'b0;
      set_ret('0);

      // Reset state
      step();
      step();
      check("rst_valid", bus.o_valid, 0);
      check("rst_data", bus.o_data, 0);
      check("rst_sel", bus.o_sel, 0);
      check("rst_err", bus.o_credit_err, 0);
      check("rst_ready", bus.o_ready, 1);
      rst = 1'b0;
      step();
      check("idle_valid", bus.o_valid, 0);

      // Eight beats spread round-robin, then credits exhausted
      bus.i_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.i_data = 16'h00A0 + 16'(k);
         check($sformatf("rr_ready_%0d", k), bus.o_ready, 1);
         step();
         check($sformatf("rr_valid_%0d", k), bus.o_valid, 1);
         check($sformatf("rr_sel_%0d", k), bus.o_sel, k % 4);
         check($sformatf("rr_data_%0d", k), bus.o_data, 32'h00A0 + k);
      end
      check("drained_ready", bus.o_ready, 0);
      bus.i_data = 16'h00FF;
      step();
      check("no9_valid", bus.o_valid, 0);
      check("no9_sel_hold", bus.o_sel, 3);
      check("no9_data_hold", bus.o_data, 16'h00A7);
      bus.i_valid = 1'b0;

      // Single credit return on channel 2
      set_ret(4'b0100);
      #1;
      check("ret_no_fwd", bus.o_ready, 0);
      step();
      set_ret('0);
      check("ret2_ready", bus.o_ready, 1);
      bus.i_valid = 1'b1;
      bus.i_data  = 16'h00B0;
      step();
      bus.i_valid = 1'b0;
      check("ret2_valid", bus.o_valid, 1);
      check("ret2_sel", bus.o_sel, 2);
      check("ret2_data", bus.o_data, 16'h00B0);
      check("ret2_ready_fall", bus.o_ready, 0);

      // Channel 1 at one credit: accept plus same-cycle return nets to zero
      set_ret(4'b0010);
      step();
      set_ret(4'b0010);
      bus.i_valid = 1'b1;
      bus.i_data  = 16'h00C1;
      step();
      set_ret('0);
      check("net0_sel", bus.o_sel, 1);
      check("net0_data", bus.o_data, 16'h00C1);
      check("net0_err", bus.o_credit_err, 0);
      check("net0_ready", bus.o_ready, 1);
      bus.i_data = 16'h00C2;
      step();
      bus.i_valid = 1'b0;
      check("net0_sel2", bus.o_sel, 1);
      check("net0_one_left", bus.o_ready, 0);

      // Overflow on channel 0 sets the sticky error
      set_ret(4'b0001);
      step();
      step();
      check("fill0_err", bus.o_credit_err, 0);
      step();
      set_ret('0);
      check("ovf_err", bus.o_credit_err, 1);
      check("ovf_ready", bus.o_ready, 1);
      bus.i_valid = 1'b1;
      bus.i_data  = 16'h00D0;
      step();
      bus.i_valid = 1'b0;
      check("ovf_sel", bus.o_sel, 0);
      check("ovf_err_sticky1", bus.o_credit_err, 1);

      // Simultaneous returns on channels 1 and 3, then drain with wrap
      set_ret(4'b1010);
      step();
      set_ret('0);
      check("multi_err_sticky", bus.o_credit_err, 1);
      bus.i_valid = 1'b1;
      bus.i_data  = 16'h00E0;
      step();
      check("multi_sel0", bus.o_sel, 1);
      bus.i_data = 16'h00E1;
      step();
      check("multi_sel1", bus.o_sel, 3);
      bus.i_data = 16'h00E2;
      step();
      bus.i_valid = 1'b0;
      check("multi_sel2", bus.o_sel, 0);
      check("multi_data2", bus.o_data, 16'h00E2);
      check("multi_drained", bus.o_ready, 0);

      // Reset mid-beat drops the beat asynchronously
      set_ret(4'b0100);
      step();
      set_ret('0);
      bus.i_valid = 1'b1;
      bus.i_data  = 16'h0055;
      step();
      bus.i_valid = 1'b0;
      check("pre_rst_valid", bus.o_valid, 1);
      check("pre_rst_data", bus.o_data, 16'h0055);
      rst = 1'b1;
      #1;
      check("async_valid", bus.o_valid, 0);
      check("async_data", bus.o_data, 0);
      check("async_err", bus.o_credit_err, 0);
      step();
      rst = 1'b0;
      step();
      check("post_rst_valid", bus.o_valid, 0);
      check("post_rst_ready", bus.o_ready, 1);
      bus.i_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.i_data = 16'h0066 + 16'(k);
         step();
         check($sformatf("post_rst_sel_%0d", k), bus.o_sel, k % 4);
      end
      check("post_rst_drained", bus.o_ready, 0);
      bus.i_valid = 1'b0;

`ifdef CHANNEL_DISPATCHER_STALL_CNT_EN
      check("stall_start", bus.o_stall_cnt, 0);
      bus.i_valid = 1'b1;
      for (int k = 0; k < 10; k++) step();
      bus.i_valid = 1'b0;
      check("stall_cnt", bus.o_stall_cnt, 10);
      step();
      check("stall_hold", bus.o_stall_cnt, 10);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/channel_dispatcher.md
CHANNEL_DISPATCHER -- requirements
Module: channel_dispatcher

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the payload bit width.
REQ-002 Parameter NUM_OUTPUT, default 8, SHALL set the number of downstream channels (range 2..256).
REQ-003 Parameter CREDIT_MAX, default 4, SHALL set the per-channel credit ceiling (range 1..255).
REQ-004 Derived SEL_W = $clog2(NUM_OUTPUT) and CRD_W = $clog2(CREDIT_MAX+1) SHALL size the index and counter fields.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 Ports: i_clk, input, 1, rising-edge clock.
REQ-007 Ports: i_rst, input, 1, asynchronous active-high reset.
REQ-008 Ports: i_data, input, DATA_WIDTH, upstream payload.
REQ-009 Ports: i_valid, input, 1, upstream payload present.
REQ-010 Ports: o_ready, output, 1, payload accepted this cycle when i_valid is also high.
REQ-011 Ports: i_credit_return, input, unpacked [NUM_OUTPUT] x 1, one credit returned per asserted channel per cycle.
REQ-012 Ports: o_data, o_sel, o_valid, outputs, DATA_WIDTH, SEL_W and 1, registered beat to the downstream 1-to-N demux data, select and valid inputs.
REQ-013 Ports: o_credit_err, output, 1, sticky credit-overflow flag.

Function
REQ-014 Each channel SHALL hold a CRD_W-bit credit counter; a channel is eligible when its count is greater than 0.
REQ-015 o_ready SHALL be combinational and high exactly when at least one channel is eligible; it SHALL NOT depend on i_valid.
REQ-016 Accept = i_valid && o_ready; on accept the block SHALL choose the first eligible channel searching upward from rr_ptr with wrap at NUM_OUTPUT-1 -> 0.
REQ-017 On accept, o_data and o_sel SHALL be registered with i_data and the chosen index, and o_valid SHALL be 1 on the next cycle (latency 1).
REQ-018 o_valid SHALL be high for exactly one cycle per accept; with no accept, o_valid SHALL be 0 and o_data/o_sel SHALL hold their last values.
REQ-019 On accept, rr_ptr SHALL become (chosen+1) mod NUM_OUTPUT; otherwise rr_ptr SHALL hold.
REQ-020 On accept, the chosen channel's credit SHALL decrement by 1; a simultaneous return on the same channel SHALL leave it unchanged (net 0).
REQ-021 A return to a channel at CREDIT_MAX with no same-cycle decrement SHALL be discarded, and o_credit_err SHALL be set, sticky until reset.
REQ-022 Returns on multiple channels in one cycle SHALL all be applied independently.
REQ-023 A return SHALL take effect on the next cycle; eligibility SHALL NOT be forwarded combinationally from i_credit_return.

Reset
REQ-024 While i_rst is high, o_valid, o_data, o_sel, rr_ptr and o_credit_err SHALL be 0, and every credit counter SHALL be CREDIT_MAX.
REQ-025 A reset asserted mid-operation SHALL drop any registered beat; o_valid SHALL fall asynchronously and SHALL NOT reassert until a new accept.

Configuration
REQ-026 When CHANNEL_DISPATCHER_STALL_CNT_EN is defined, the block SHALL add output o_stall_cnt, 32 bits, which increments on every cycle with i_valid && !o_ready, saturates at 2^32-1, and resets to 0.
REQ-027 When CHANNEL_DISPATCHER_STALL_CNT_EN is not defined, o_stall_cnt SHALL NOT exist, and the remaining behaviour SHALL be identical.

Structure
REQ-028 The package channel_dispatch_pkg SHALL hold the width helper functions (sel_w, crd_w), and the block SHALL import it.
REQ-029 The round-robin search SHALL be a sub-module named rr_picker with inputs eligible[N] and ptr, and outputs any and idx; it SHALL be purely combinational.

Verification (NUM_OUTPUT=4, CREDIT_MAX=2, DATA_WIDTH=16)
REQ-030 Reset, then i_valid=1 with data 0xA0..0xA7 and no returns -> o_sel 0,1,2,3,0,1,2,3 on consecutive cycles, then o_ready=0 and no 9th beat.
REQ-031 Drain all credits, then return a credit on channel 2 only -> o_ready rises the next cycle, the next beat goes to o_sel=2, and o_ready falls again.
REQ-032 Channel 1 at 1 credit, accept to channel 1 with a same-cycle return on channel 1 -> channel 1 credit stays 1, o_credit_err=0.
REQ-033 Channel 0 at 2 credits with a return on channel 0 -> o_credit_err=1 and stays 1 through later traffic until i_rst.
REQ-034 Assert i_rst for 1 cycle while o_valid=1 carrying 0x55 -> o_valid=0 immediately, credits restore to 2, and the next accept goes to o_sel=0.
REQ-035 With CHANNEL_DISPATCHER_STALL_CNT_EN defined, all credits zero and i_valid=1 for 10 cycles -> o_stall_cnt=10.
